// File: rtl/tge_pkt_bram_ctrl.sv
// Packet-buffer controller: writes a sample stream into a ring of fixed-length BRAM slots
// and bursts whole committed packets to the 10GbE transmitter. Full buffer drops whole packets.
module tge_pkt_bram_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int PKT_LEN    = 128,
  parameter int N_PKTS     = 4,
  localparam int AW = $clog2(PKT_LEN * N_PKTS),
  localparam int WW = $clog2(PKT_LEN),
  localparam int SW = $clog2(N_PKTS),
  localparam int CW = $clog2(N_PKTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  bram_wen,
  output logic [AW-1:0]         bram_wadd,
  output logic [DATA_WIDTH-1:0] bram_win,
  output logic                  bram_ren,
  output logic [AW-1:0]         bram_radd,
  input  logic [DATA_WIDTH-1:0] bram_wout,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_eof,
  input  logic                  tx_afull,
  output logic [CW-1:0]         pkt_count,
  output logic                  overflow,
  output logic [15:0]           ovf_cnt,
  output logic                  dbg_rd_state
);

  // Handshake: din is taken on every cycle din_valid is high (no ready); tx_valid has no
  // ready either -- tx_afull only gates the start of a packet, never a burst in progress.

  typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} rd_state_t;

  localparam logic [WW-1:0] LAST_WORD = WW'(PKT_LEN - 1);
  localparam logic [CW-1:0] FULL      = CW'(N_PKTS);

  rd_state_t             r_state, w_state_n;
  logic [WW-1:0]         r_wword, r_rword, w_rword_n;
  logic [SW-1:0]         r_wslot, r_rslot, w_rslot_n;
  logic                  r_drop, r_wen, r_ren, r_last, r_txv, r_eof, r_ovf;
  logic [AW-1:0]         r_wadd;
  logic [DATA_WIDTH-1:0] r_win;
  logic [CW-1:0]         r_pkt_count;
  logic [15:0]           r_ovf_cnt;
  logic                  w_drop_now, w_start_drop, w_accept, w_commit, w_release;

  // Fullness is judged only at a packet boundary; mid-packet the drop flag carries the verdict.
  always_comb begin
    w_drop_now   = (r_wword == '0) ? (r_pkt_count == FULL) : r_drop;
    w_start_drop = din_valid && (r_wword == '0) && (r_pkt_count == FULL);
    w_accept     = din_valid && !w_drop_now;
    w_commit     = w_accept && (r_wword == LAST_WORD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wword   <= '0;
      r_wslot   <= '0;
      r_drop    <= 1'b0;
      r_wen     <= 1'b0;
      r_wadd    <= '0;
      r_win     <= '0;
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else begin
      r_wen <= w_accept;
      r_ovf <= w_start_drop;
      if (w_accept) begin
        r_wadd <= {r_wslot, r_wword};
        r_win  <= din;
      end
      if (din_valid) begin
        r_wword <= r_wword + 1'b1;
        r_drop  <= (r_wword == LAST_WORD) ? 1'b0 : w_drop_now;
      end
      if (w_commit) r_wslot <= r_wslot + 1'b1;
      if (w_start_drop && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_rword_n = r_rword;
    w_rslot_n = r_rslot;
    w_release = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_pkt_count != '0) && !tx_afull) begin
          w_state_n = S_READ;
          w_rword_n = '0;
        end
      end
      S_READ: begin
        w_rword_n = r_rword + 1'b1;
        if (r_rword == LAST_WORD) begin
          w_state_n = S_IDLE;
          w_rslot_n = r_rslot + 1'b1;
          w_release = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // The read address is held in r_rslot/r_rword, so it lines up with r_ren without extra flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rword <= '0;
      r_rslot <= '0;
      r_ren   <= 1'b0;
      r_last  <= 1'b0;
      r_txv   <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_rword <= w_rword_n;
      r_rslot <= w_rslot_n;
      r_ren   <= (w_state_n == S_READ);
      r_last  <= (w_state_n == S_READ) && (w_rword_n == LAST_WORD);
      r_txv   <= r_ren;
      r_eof   <= r_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_count <= '0;
    end else if (w_commit && !w_release) begin
      r_pkt_count <= r_pkt_count + 1'b1;
    end else if (!w_commit && w_release) begin
      r_pkt_count <= r_pkt_count - 1'b1;
    end
  end

  assign bram_wen     = r_wen;
  assign bram_wadd    = r_wadd;
  assign bram_win     = r_win;
  assign bram_ren     = r_ren;
  assign bram_radd    = {r_rslot, r_rword};
  assign tx_data      = bram_wout;
  assign tx_valid     = r_txv;
  assign tx_eof       = r_eof;
  assign pkt_count    = r_pkt_count;
  assign overflow     = r_ovf;
  assign ovf_cnt      = r_ovf_cnt;
  assign dbg_rd_state = r_state;

endmodule

// File: tb/tb_tge_pkt_bram_ctrl.sv
// Bench for tge_pkt_bram_ctrl: BRAM model, packet-level reference model with expected queues,
// directed scenarios plus a randomized phase.
module tb_tge_pkt_bram_ctrl;
  localparam int DW = 64;
  localparam int PL = 8;
  localparam int NP = 4;
  localparam int AW = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          tx_afull = 1'b0;
  logic          bram_wen, bram_ren, tx_valid, tx_eof, overflow, dbg_rd_state;
  logic [AW-1:0] bram_wadd, bram_radd;
  logic [DW-1:0] bram_win, bram_wout, tx_data;
  logic [CW-1:0] pkt_count;
  logic [15:0]   ovf_cnt;

  tge_pkt_bram_ctrl #(.DATA_WIDTH(DW), .PKT_LEN(PL), .N_PKTS(NP)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .bram_wen(bram_wen), .bram_wadd(bram_wadd), .bram_win(bram_win),
    .bram_ren(bram_ren), .bram_radd(bram_radd), .bram_wout(bram_wout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_eof(tx_eof), .tx_afull(tx_afull),
    .pkt_count(pkt_count), .overflow(overflow), .ovf_cnt(ovf_cnt),
    .dbg_rd_state(dbg_rd_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // External simple-dual-port BRAM with 1-cycle registered read
  logic [DW-1:0] mem [PL*NP];
  initial begin
    for (int i = 0; i < PL*NP; i++) mem[i] = '0;
    bram_wout = '0;
  end
  always @(posedge clk) begin
    if (bram_wen) mem[bram_wadd] <= bram_win;
    if (bram_ren) bram_wout <= mem[bram_radd];
  end

  // Checking
  int n_tests = 0;
  int n_fail  = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: packet-level bookkeeping per the buffer rules
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [DW:0]      exp_tx_q[$];
  logic [DW-1:0]    cur_pkt[$];
  int  m_count = 0, m_wword = 0, m_wslot = 0, m_tx_left = 0, m_ovf = 0, cyc = 0;
  bit  m_drop = 0, m_txv = 0, m_wen = 0, m_ovf_pulse = 0;

  always @(posedge clk) begin : model
    bit commit, release_now, start;
    cyc++;
    if (rst) begin
      m_count = 0; m_wword = 0; m_wslot = 0; m_tx_left = 0; m_ovf = 0;
      m_drop = 0; m_txv = 0; m_wen = 0; m_ovf_pulse = 0;
      exp_wr_q.delete(); exp_tx_q.delete(); cur_pkt.delete();
    end else begin
      commit = 0; m_wen = 0; m_ovf_pulse = 0;
      if (din_valid) begin
        if (m_wword == 0) begin
          m_drop = (m_count == NP);
          if (m_drop) begin
            m_ovf_pulse = 1;
            if (m_ovf < 65535) m_ovf++;
          end
        end
        if (!m_drop) begin
          exp_wr_q.push_back({AW'(m_wslot * PL + m_wword), din});
          cur_pkt.push_back(din);
          m_wen = 1;
        end
        m_wword++;
        if (m_wword == PL) begin
          m_wword = 0;
          if (!m_drop) begin
            for (int i = 0; i < PL; i++) exp_tx_q.push_back({(i == PL-1) ? 1'b1 : 1'b0, cur_pkt[i]});
            m_wslot = (m_wslot + 1) % NP;
            commit = 1;
          end
          cur_pkt.delete();
          m_drop = 0;
        end
      end
      release_now = (m_tx_left == 1);
      start = (m_tx_left == 0) && (m_count > 0) && !tx_afull;
      m_txv = (m_tx_left > 0);
      if (start) m_tx_left = PL;
      else if (m_tx_left > 0) m_tx_left--;
      m_count = m_count + int'(commit) - int'(release_now);
    end
  end

  // Scoreboard: every cycle, away from the rising edge
  bit chk_en = 0, watch = 0;
  int tx_first = -1, tx_eof_cyc = -1;
  always @(negedge clk) begin : scoreboard
    logic [AW+DW-1:0] ew;
    logic [DW:0]      et;
    if (chk_en) begin
      chk("pkt_count", pkt_count, m_count);
      chk("ovf_cnt", ovf_cnt, m_ovf);
      chk("overflow", overflow, m_ovf_pulse);
      chk("bram_ren", bram_ren, m_tx_left > 0);
      chk("tx_valid", tx_valid, m_txv);
      chk("bram_wen", bram_wen, m_wen);
      if (bram_wen) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          ew = exp_wr_q.pop_front();
          chk("wr_addr", bram_wadd, ew[AW+DW-1:DW]);
          chk("wr_data", bram_win, ew[DW-1:0]);
        end
      end
      if (tx_valid) begin
        if (exp_tx_q.size() == 0) chk("tx_unexpected", 1, 0);
        else begin
          et = exp_tx_q.pop_front();
          chk("tx_data", tx_data, et[DW-1:0]);
          chk("tx_eof", tx_eof, et[DW]);
        end
        if (watch && tx_first < 0) tx_first = cyc;
        if (watch && tx_eof) tx_eof_cyc = cyc;
      end else begin
        chk("tx_eof_idle", tx_eof, 0);
      end
    end
  end

  // Driver tasks
  task automatic drive_word(input logic [DW-1:0] d);
    din = d;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int d1;
    int guard;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);

    // Single packet 0x1..0x8: latency and eof placement
    d1 = cyc;
    watch = 1;
    for (int i = 1; i <= PL; i++) drive_word(DW'(i));
    idle(20);
    watch = 0;
    chk("t1_first_tx_cycle", tx_first, d1 + 10);
    chk("t1_eof_cycle", tx_eof_cyc, d1 + 17);
    chk("t1_count_zero", pkt_count, 0);

    // Four back-to-back packets
    for (int i = 0; i < 4*PL; i++) drive_word({$urandom, $urandom});
    idle(60);
    chk("t2_no_ovf", ovf_cnt, 0);

    // Fill with transmitter held off; fifth packet dropped
    tx_afull = 1'b1;
    for (int i = 0; i < 5*PL; i++) drive_word({$urandom, $urandom});
    chk("t3_full", pkt_count, NP);
    chk("t3_ovf_cnt", ovf_cnt, 1);
    tx_afull = 1'b0;
    idle(60);
    chk("t3_drained", pkt_count, 0);

    // tx_afull rises mid-burst: burst finishes, next packet held
    for (int i = 0; i < 2*PL; i++) begin
      if (i == 11) tx_afull = 1'b1;
      drive_word({$urandom, $urandom});
    end
    idle(30);
    chk("t4_held", pkt_count, 1);
    tx_afull = 1'b0;
    idle(30);
    chk("t4_drained", pkt_count, 0);

    // Randomized traffic and back-pressure
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) tx_afull = ~tx_afull;
      din = {$urandom, $urandom};
      din_valid = ($urandom_range(0, 9) < 8);
      @(negedge clk);
    end
    guard = 0;
    while (m_wword != 0 && guard < PL) begin
      drive_word({$urandom, $urandom});
      guard++;
    end
    chk("t5_aligned", m_wword == 0, 1);
    tx_afull = 1'b0;
    idle(80);
    chk("t5_drained", pkt_count, 0);

    // Reset mid-write and mid-transmit
    for (int i = 0; i < PL + 4; i++) drive_word({$urandom, $urandom});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_txv_after_rst", tx_valid, 0);
    chk("t6_count_after_rst", pkt_count, 0);
    drive_word(64'hA5A5_0000_0000_0001);
    chk("t6_first_wen", bram_wen, 1);
    chk("t6_first_addr", bram_wadd, 0);
    for (int i = 1; i < PL; i++) drive_word({$urandom, $urandom});
    idle(40);
    chk("t6_drained", pkt_count, 0);

    chk("wr_q_empty", exp_wr_q.size(), 0);
    chk("tx_q_empty", exp_tx_q.size(), 0);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
